algo_2rw_b740_t1_bank: RTL and testbench

//  Physical dual-port bank behind the 2rw_b740 algorithm core: one instance per t1 bank, fed by one

---
 rtl/algo_2rw_b740_t1_bank_if.sv | 34 +++
 rtl/algo_2rw_b740_t1_bank.sv | 122 ++++++++++++
 tb/tb_algo_2rw_b740_t1_bank.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/algo_2rw_b740_t1_bank_if.sv
// Command/response bundle for one physical dual-port bank (ports A and B).
// The master drives row commands. The slave (the bank) returns read data and valid pulses.
interface algo_2rw_b740_t1_bank_if #(
  parameter int PHYWDTH = 128,
  parameter int BITSROW = 12
);
  logic               readA;
  logic               writeA;
  logic [BITSROW-1:0] addrA;
  logic [PHYWDTH-1:0] dinA;
  logic [PHYWDTH-1:0] bwA;
  logic [PHYWDTH-1:0] doutA;
  logic               dvldA;

  logic               readB;
  logic               writeB;
  logic [BITSROW-1:0] addrB;
  logic [PHYWDTH-1:0] dinB;
  logic [PHYWDTH-1:0] bwB;
  logic [PHYWDTH-1:0] doutB;
  logic               dvldB;

  modport master (
    output readA, writeA, addrA, dinA, bwA,
    output readB, writeB, addrB, dinB, bwB,
    input  doutA, dvldA, doutB, dvldB
  );

  modport slave (
    input  readA, writeA, addrA, dinA, bwA,
    input  readB, writeB, addrB, dinB, bwB,
    output doutA, dvldA, doutB, dvldB
  );
endinterface

// File: rtl/algo_2rw_b740_t1_bank.sv
// Physical dual-port bank for the 2rw_b740 core.
// Structure: optional command flop, bit-masked row storage, and a fixed-latency read pipeline per port.
// Latency is FLOPCMD + SRAM_DELAY.
// Ordering within one array cycle:
//   - A read on one port returns the row as it was before a write on the other port.
//   - When A and B write the same row, A's write is applied first and B's write second.
// Optional feature: define ALGO_2RW_B740_T1_COLLCHK_EN to add the coll_err write-write collision flag.
module algo_2rw_b740_t1_bank #(
  parameter int PHYWDTH    = 128,
  parameter int NUMSROW    = 4096,
  parameter int BITSROW    = 12,
  parameter int SRAM_DELAY = 2,
  parameter int FLOPCMD    = 0
) (
  input  logic clk,
  input  logic rst,
`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
  output logic coll_err,
`endif
  algo_2rw_b740_t1_bank_if.slave bus
);

  // Index width that exactly covers the implemented rows.
  // Out-of-range addresses are filtered before indexing.
  localparam int IDXW = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;

  typedef struct packed {
    logic               rd;
    logic               wr;
    logic [BITSROW-1:0] addr;
    logic [PHYWDTH-1:0] din;
    logic [PHYWDTH-1:0] bw;
  } cmdT;

  cmdT  [1:0]                            cmdIn;
  cmdT  [1:0]                            arrCmd;
  logic [1:0]                            inRange;
  logic [1:0]                            arrRd;
  logic [1:0]                            arrWr;
  logic [1:0][IDXW-1:0]                  idx;
  logic [1:0][PHYWDTH-1:0]               rdData;
  logic [PHYWDTH-1:0]                    wrRowA;
  logic [PHYWDTH-1:0]                    baseB;
  logic [PHYWDTH-1:0]                    wrRowB;
  logic [1:0][SRAM_DELAY:1]              vldPipe;
  logic [1:0][SRAM_DELAY:1][PHYWDTH-1:0] datPipe;
  logic [PHYWDTH-1:0]                    mem [NUMSROW];

  assign cmdIn[0] = '{bus.readA, bus.writeA, bus.addrA, bus.dinA, bus.bwA};
  assign cmdIn[1] = '{bus.readB, bus.writeB, bus.addrB, bus.dinB, bus.bwB};

  if (FLOPCMD != 0) begin : gFlop
    cmdT [1:0] cmdQ;
    // One extra register stage in front of the array. Clearing it on reset drops queued commands.
    always_ff @(posedge clk) begin
      if (!rst) cmdQ <= '0;
      else      cmdQ <= cmdIn;
    end
    assign arrCmd = cmdQ;
  end else begin : gNoFlop
    assign arrCmd = cmdIn;
  end

  // Array-stage decode.
  // - A write on a port drops a read on the same port.
  // - Reset gates every command.
  // - Out-of-range rows read as zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      inRange[p] = 32'(arrCmd[p].addr) < 32'(NUMSROW);
      idx[p]     = IDXW'(arrCmd[p].addr);
      arrWr[p]   = rst & arrCmd[p].wr & inRange[p];
      arrRd[p]   = rst & arrCmd[p].rd & ~arrCmd[p].wr;
      rdData[p]  = inRange[p] ? mem[idx[p]] : '0;
    end
  end

  // Masked row merge.
  // When both ports hit one row, B's write merges on top of A's result, so overlapping bits take dinB.
  always_comb begin
    wrRowA = (mem[idx[0]] & ~arrCmd[0].bw) | (arrCmd[0].din & arrCmd[0].bw);
    baseB  = (arrWr[0] && idx[0] == idx[1]) ? wrRowA : mem[idx[1]];
    wrRowB = (baseB & ~arrCmd[1].bw) | (arrCmd[1].din & arrCmd[1].bw);
  end

  // Storage update. Reset does not clear the contents.
  // The later assignment (B) wins when both ports write the same row.
  always_ff @(posedge clk) begin
    if (arrWr[0]) mem[idx[0]] <= wrRowA;
    if (arrWr[1]) mem[idx[1]] <= wrRowB;
  end

  // Per-port read pipeline. Stage s holds data s cycles after the array cycle.
  // The last stage is the output register and loads only when a valid read arrives, so it holds between reads.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst) begin
        vldPipe[p] <= '0;
        datPipe[p] <= '0;
      end else begin
        vldPipe[p] <= (vldPipe[p] << 1) | SRAM_DELAY'(arrRd[p]);
        for (int s = SRAM_DELAY; s >= 2; s--)
          if (s < SRAM_DELAY || vldPipe[p][s-1]) datPipe[p][s] <= datPipe[p][s-1];
        if (SRAM_DELAY > 1 || arrRd[p]) datPipe[p][1] <= rdData[p];
      end
    end
  end

  assign bus.dvldA = vldPipe[0][SRAM_DELAY];
  assign bus.doutA = datPipe[0][SRAM_DELAY];
  assign bus.dvldB = vldPipe[1][SRAM_DELAY];
  assign bus.doutB = datPipe[1][SRAM_DELAY];

`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
  // Flag an in-range write-write collision on one row, one cycle after the array cycle.
  always_ff @(posedge clk) begin
    if (!rst) coll_err <= 1'b0;
    else      coll_err <= arrWr[0] & arrWr[1] & (idx[0] == idx[1]);
  end
`endif

endmodule

// File: tb/tb_algo_2rw_b740_t1_bank.sv
// Directed bench for algo_2rw_b740_t1_bank.
// Uses two instances:
//   dut0: default geometry, no command flop.
//   dut1: command flop enabled, 16 rows, 5-bit address, so out-of-range rows exist.
module tb_algo_2rw_b740_t1_bank;
  localparam int W = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  algo_2rw_b740_t1_bank_if #(.PHYWDTH(W), .BITSROW(12)) b0 ();
  algo_2rw_b740_t1_bank_if #(.PHYWDTH(W), .BITSROW(5))  b1 ();

`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
  logic coll0, coll1;
`endif

  algo_2rw_b740_t1_bank #(.PHYWDTH(W), .NUMSROW(4096), .BITSROW(12), .SRAM_DELAY(2), .FLOPCMD(0)) dut0 (
    .clk(clk),
    .rst(rst),
`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
    .coll_err(coll0),
`endif
    .bus(b0)
  );

  algo_2rw_b740_t1_bank #(.PHYWDTH(W), .NUMSROW(16), .BITSROW(5), .SRAM_DELAY(2), .FLOPCMD(1)) dut1 (
    .clk(clk),
    .rst(rst),
`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
    .coll_err(coll1),
`endif
    .bus(b1)
  );

  logic [W-1:0] ones;
  logic [W-1:0] a5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.readA = 0; b0.writeA = 0; b0.addrA = '0; b0.dinA = '0; b0.bwA = '0;
    b0.readB = 0; b0.writeB = 0; b0.addrB = '0; b0.dinB = '0; b0.bwB = '0;
    b1.readA = 0; b1.writeA = 0; b1.addrA = '0; b1.dinA = '0; b1.bwA = '0;
    b1.readB = 0; b1.writeB = 0; b1.addrB = '0; b1.dinB = '0; b1.bwB = '0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    ones = {W{1'b1}};
    a5   = {(W/8){8'hA5}};
    idle();
    rst = 0;
    repeat (3) tick();
    chk ("rst_doutA", b0.doutA, '0);
    chk1("rst_dvldA", b0.dvldA, 1'b0);
    chk ("rst_doutB", b0.doutB, '0);
    chk1("rst_dvldB", b0.dvldB, 1'b0);
    chk1("rst_dvld1", b1.dvldA, 1'b0);
`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
    chk1("rst_coll0", coll0, 1'b0);
    chk1("rst_coll1", coll1, 1'b0);
`endif
    rst = 1;

    // Zero rows 9, 7 and 12 before the partial-mask tests.
    b0.writeA = 1; b0.addrA = 12'd9; b0.dinA = '0; b0.bwA = ones;
    b0.writeB = 1; b0.addrB = 12'd7; b0.dinB = '0; b0.bwB = ones;
    tick(); idle();
    b0.writeA = 1; b0.addrA = 12'd12; b0.dinA = '0; b0.bwA = ones;
    tick(); idle();

    // Write A row 5, then read B row 5 one cycle later. Data must appear two cycles after the read.
    b0.writeA = 1; b0.addrA = 12'd5; b0.dinA = a5; b0.bwA = ones;
    tick(); idle();
    b0.readB = 1; b0.addrB = 12'd5;
    tick(); idle();
    chk1("t1_dvldB_early", b0.dvldB, 1'b0);
    tick();
    chk1("t1_dvldB", b0.dvldB, 1'b1);
    chk ("t1_doutB", b0.doutB, a5);
    tick();
    chk1("t1_dvldB_pulse", b0.dvldB, 1'b0);
    chk ("t1_doutB_hold", b0.doutB, a5);

    // Partial mask: only the low byte of row 9 is written.
    b0.writeA = 1; b0.addrA = 12'd9; b0.dinA = ones; b0.bwA = W'(8'hFF);
    tick(); idle();
    b0.readA = 1; b0.addrA = 12'd9;
    tick(); idle(); tick();
    chk1("t2_dvldA", b0.dvldA, 1'b1);
    chk ("t2_doutA", b0.doutA, W'(8'hFF));

    // Same-row write-write: B wins.
    b0.writeA = 1; b0.addrA = 12'd3; b0.dinA = W'(1); b0.bwA = ones;
    b0.writeB = 1; b0.addrB = 12'd3; b0.dinB = W'(2); b0.bwB = ones;
    tick(); idle();
`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
    chk1("t3_coll", coll0, 1'b1);
`endif
    b0.readA = 1; b0.addrA = 12'd3;
    tick(); idle();
`ifdef ALGO_2RW_B740_T1_COLLCHK_EN
    chk1("t3_coll_clear", coll0, 1'b0);
`endif
    tick();
    chk ("t3_doutA", b0.doutA, W'(2));

    // Overlapping masks on row 12.
    // A writes 1s to bits 7:4 (giving 0xF0). B then clears bits 5:2, so 0xF0 & ~0x3C = 0xC0.
    b0.writeA = 1; b0.addrA = 12'd12; b0.dinA = ones; b0.bwA = W'(8'hF0);
    b0.writeB = 1; b0.addrB = 12'd12; b0.dinB = '0;   b0.bwB = W'(8'h3C);
    tick(); idle();
    b0.readB = 1; b0.addrB = 12'd12;
    tick(); idle(); tick();
    chk ("merge_doutB", b0.doutB, W'(8'hC0));

    // Read-first against the other port's write, then read-after-write sees the new data.
    b0.writeA = 1; b0.addrA = 12'd7; b0.dinA = W'(4'hF); b0.bwA = ones;
    b0.readB  = 1; b0.addrB = 12'd7;
    tick(); idle();
    b0.readB  = 1; b0.addrB = 12'd7;
    tick(); idle();
    chk1("t4_dvldB_old", b0.dvldB, 1'b1);
    chk ("t4_doutB_old", b0.doutB, '0);
    tick();
    chk1("t4_dvldB_new", b0.dvldB, 1'b1);
    chk ("t4_doutB_new", b0.doutB, W'(4'hF));

    // Read and write on the same port in the same cycle: the write lands and the read is dropped.
    b0.writeA = 1; b0.readA = 1; b0.addrA = 12'd11; b0.dinA = W'(5); b0.bwA = ones;
    tick(); idle(); tick();
    chk1("rw_same_port_no_dvld", b0.dvldA, 1'b0);
    chk ("rw_same_port_hold", b0.doutA, W'(2));
    b0.readA = 1; b0.addrA = 12'd11;
    tick(); idle(); tick();
    chk ("rw_same_port_data", b0.doutA, W'(5));

    // Reset one cycle before a read returns.
    // The read must be dropped, and a write presented during reset must be ignored.
    b0.readA = 1; b0.addrA = 12'd5;
    tick(); idle();
    rst = 0;
    b0.writeB = 1; b0.addrB = 12'd5; b0.dinB = '0; b0.bwB = ones;
    tick(); idle();
    chk1("t6_dvldA_dropped", b0.dvldA, 1'b0);
    chk ("t6_doutA_cleared", b0.doutA, '0);
    rst = 1;
    tick();
    chk1("t6_dvldA_stays_low", b0.dvldA, 1'b0);
    b0.readA = 1; b0.addrA = 12'd5;
    tick(); idle(); tick();
    chk1("t6_dvldA_after", b0.dvldA, 1'b1);
    chk ("t6_row_preserved", b0.doutA, a5);

    // Command flop: preload rows 0..15 of dut1, then stream reads.
    // Expect a 3-cycle latency and in-order data.
    for (int i = 0; i < 16; i++) begin
      b1.writeA = 1; b1.addrA = 5'(i); b1.dinA = W'(i + 100); b1.bwA = ones;
      tick();
    end
    idle();
    // Row 20 is out of range (16 rows): this write must not land anywhere.
    b1.writeA = 1; b1.addrA = 5'd20; b1.dinA = ones; b1.bwA = ones;
    tick(); idle();
    for (int k = 0; k < 19; k++) begin
      b1.readA = (k < 16); b1.addrA = 5'(k);
      tick();
      begin
        int  j;
        logic expV;
        j = k - 2;
        expV = (j >= 0) && (j < 16);
        chk1($sformatf("t5_dvld_k%0d", k), b1.dvldA, expV);
        if (expV) chk($sformatf("t5_dout_k%0d", k), b1.doutA, W'(j + 100));
      end
    end
    idle();
    b1.readA = 1; b1.addrA = 5'd20;
    tick(); idle(); tick(); tick();
    chk1("oor_dvld", b1.dvldA, 1'b1);
    chk ("oor_dout_zero", b1.doutA, '0);
    b1.readA = 1; b1.addrA = 5'd4;
    tick(); idle(); tick(); tick();
    chk ("oor_no_alias", b1.doutA, W'(104));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
